// File: rtl/parity_frame_checker_if.sv
// parity_frame_checker_if
// Groups the two handshake channels of parity_frame_checker.
//   Input side : in_valid, in_ready, in_data[7:0] ({d[6:4], p, d[3:0]}), control
//   Output side: out_valid, out_ready, out_data[6:0], out_err
// master: the environment (upstream producer + downstream consumer).
// slave : the checker itself.
interface parity_frame_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       control;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_data;
  logic       out_err;

  modport master (
    output in_valid, in_data, control, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_data, control, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/parity_frame_checker.sv
// parity_frame_checker
// Strips the majority bit at position 4 of each encoded word, recomputes it
// under the `control` rule and flags a mismatch. {err, payload} is buffered
// in a FIFO_DEPTH-entry FIFO and released on a valid/ready handshake.
// Saturating counters track accepted words and errored words.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   bus (slave)        input/output handshake channels
//   clear_counts       synchronous clear of both statistics counters
//   word_count         accepted words, saturating
//   err_count          accepted words with err=1, saturating
module parity_frame_checker #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_frame_checker_if.slave bus,
  input  logic                 clear_counts,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic [CNT_WIDTH-1:0] err_count
);
  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       err;
    logic [6:0] payload;
  } entry_t;

  entry_t               mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]          cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] wc_q, wc_d, ec_q, ec_d;
  logic                 push, pop;
  logic [2:0]           ones;
  logic                 exp_bit;
  entry_t               wr_entry;

  // Decode and recompute the expected bit.
  always_comb begin
    wr_entry.payload = {bus.in_data[7:5], bus.in_data[3:0]};
    ones = '0;
    for (int i = 0; i < 7; i++) ones = ones + {2'b00, wr_entry.payload[i]};
    // Seven bits cannot tie, so the two rules are exact complements.
    exp_bit      = bus.control ? (ones >= 3'd4) : (ones <= 3'd3);
    wr_entry.err = bus.in_data[4] ^ exp_bit;
  end

  // No pass-through when full: ready depends only on registered occupancy.
  assign bus.in_ready  = rst_n && (cnt_q != FULL);
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_data  = mem_q[rd_q].payload;
  assign bus.out_err   = mem_q[rd_q].err;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    wr_d  = push ? wr_q + AW'(1) : wr_q;
    rd_d  = pop  ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Clear loads zero, then the same cycle's increment still applies.
  always_comb begin
    wc_d = clear_counts ? '0 : wc_q;
    ec_d = clear_counts ? '0 : ec_q;
    if (push && (wc_d != '1))                 wc_d = wc_d + CNT_WIDTH'(1);
    if (push && wr_entry.err && (ec_d != '1)) ec_d = ec_d + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      wc_q  <= '0;
      ec_q  <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      wc_q  <= wc_d;
      ec_q  <= ec_d;
    end
  end

  // Storage needs no reset; occupancy alone qualifies the head.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= wr_entry;
  end

  assign word_count = wc_q;
  assign err_count  = ec_q;
endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker. Two instances share one stimulus stream:
// u0 with 8-bit counters, u1 with 2-bit counters for saturation checks.
module tb_parity_frame_checker;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_counts = 1'b0;
  logic [7:0] wc0, ec0;
  logic [1:0] wc1, ec1;

  parity_frame_checker_if if0();
  parity_frame_checker_if if1();

  assign if1.in_valid  = if0.in_valid;
  assign if1.in_data   = if0.in_data;
  assign if1.control   = if0.control;
  assign if1.out_ready = if0.out_ready;

  parity_frame_checker #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(8)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .clear_counts(clear_counts),
    .word_count(wc0), .err_count(ec0));

  parity_frame_checker #(.FIFO_DEPTH(DEPTH), .CNT_WIDTH(2)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .clear_counts(clear_counts),
    .word_count(wc1), .err_count(ec1));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of {err, payload}, plain integer counters.
  logic [7:0] mq[$];
  int mw0 = 0, me0 = 0, mw1 = 0, me1 = 0;

  function automatic logic model_err(logic [7:0] d, logic c);
    int   n;
    logic e;
    n = $countones({d[7:5], d[3:0]});
    e = c ? (n >= 4) : (n <= 3);
    return d[4] != e;
  endfunction

  function automatic int sat(int v, int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  // Advance one clock edge, updating the model from pre-edge inputs.
  task automatic tick();
    logic       acc, pp, e;
    logic [7:0] w;
    acc = if0.in_valid && rst_n && (mq.size() != DEPTH);
    pp  = if0.out_ready && (mq.size() != 0);
    e   = model_err(if0.in_data, if0.control);
    w   = {e, if0.in_data[7:5], if0.in_data[3:0]};
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      mw0 = 0; me0 = 0; mw1 = 0; me1 = 0;
    end else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(w);
      if (clear_counts) begin mw0 = 0; me0 = 0; mw1 = 0; me1 = 0; end
      if (acc) begin
        mw0 = sat(mw0, 255); mw1 = sat(mw1, 3);
        if (e) begin me0 = sat(me0, 255); me1 = sat(me1, 3); end
      end
    end
    #1;
  endtask

  task automatic send(logic [7:0] d, logic c);
    if0.in_valid = 1'b1; if0.in_data = d; if0.control = c;
    tick();
    if0.in_valid = 1'b0;
  endtask

  task automatic pop1();
    if0.out_ready = 1'b1;
    tick();
    if0.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if0.in_valid = 1'b1; if0.in_data = 8'h10; if0.control = 1'b0;
    if0.out_ready = 1'b0;
    tick(); tick();
    n_vec++; if (if0.in_ready !== 1'b0 || if1.in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready: got %b/%b want 0/0", if0.in_ready, if1.in_ready); end
    n_vec++; if (if0.out_valid !== 1'b0 || if1.out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b/%b want 0/0", if0.out_valid, if1.out_valid); end
    n_vec++; if (wc0 !== 8'd0 || ec0 !== 8'd0 || wc1 !== 2'd0 || ec1 !== 2'd0) begin
      n_err++; $display("FAIL reset_counts: got %0d %0d %0d %0d want all 0", wc0, ec0, wc1, ec1); end
    if0.in_valid = 1'b0;
    rst_n = 1'b1; #1;
    n_vec++; if (if0.in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", if0.in_ready); end
  endtask

  task automatic test_good();
    send(8'h10, 1'b0);
    n_vec++; if (if0.out_valid !== 1'b1 || if0.out_data !== 7'h00 || if0.out_err !== 1'b0) begin
      n_err++; $display("FAIL good_10: v=%b d=%h e=%b want 1/00/0", if0.out_valid, if0.out_data, if0.out_err); end
    pop1();
    n_vec++; if (if0.out_valid !== 1'b0) begin
      n_err++; $display("FAIL good_pop_empty: v=%b want 0", if0.out_valid); end
    send(8'hA5, 1'b0);
    n_vec++; if (if0.out_valid !== 1'b1 || if0.out_data !== 7'h55 || if0.out_err !== 1'b0) begin
      n_err++; $display("FAIL good_A5: v=%b d=%h e=%b want 1/55/0", if0.out_valid, if0.out_data, if0.out_err); end
    pop1();
    n_vec++; if (wc0 !== 8'd2 || ec0 !== 8'd0) begin
      n_err++; $display("FAIL good_counts: wc=%0d ec=%0d want 2/0", wc0, ec0); end
  endtask

  task automatic test_errored();
    send(8'h00, 1'b0);
    n_vec++; if (if0.out_data !== 7'h00 || if0.out_err !== 1'b1 || ec0 !== 8'd1 || ec1 !== 2'd1) begin
      n_err++; $display("FAIL err_00: d=%h e=%b ec=%0d/%0d want 00/1/1/1", if0.out_data, if0.out_err, ec0, ec1); end
    pop1();
    send(8'hFF, 1'b1);
    n_vec++; if (if0.out_data !== 7'h7F || if0.out_err !== 1'b0) begin
      n_err++; $display("FAIL err_FF: d=%h e=%b want 7f/0", if0.out_data, if0.out_err); end
    pop1();
    send(8'hEF, 1'b1);
    n_vec++; if (if0.out_data !== 7'h7F || if0.out_err !== 1'b1 || ec0 !== 8'd2) begin
      n_err++; $display("FAIL err_EF: d=%h e=%b ec=%0d want 7f/1/2", if0.out_data, if0.out_err, ec0); end
    pop1();
  endtask

  task automatic test_full();
    logic [7:0] vals [4];
    logic [6:0] expd [5];
    vals = '{8'h10, 8'h30, 8'h50, 8'h70};
    expd = '{7'h00, 7'h10, 7'h20, 7'h30, 7'h40};
    if0.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if0.in_valid = 1'b1; if0.in_data = vals[i]; if0.control = 1'b0;
      tick();
    end
    n_vec++; if (if0.in_ready !== 1'b0) begin
      n_err++; $display("FAIL full_ready: got %b want 0", if0.in_ready); end
    if0.in_data = 8'h90;
    tick(); tick();
    n_vec++; if (if0.in_ready !== 1'b0 || if0.out_data !== 7'h00) begin
      n_err++; $display("FAIL full_hold: rdy=%b head=%h want 0/00", if0.in_ready, if0.out_data); end
    if0.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (if0.out_valid !== 1'b1 || if0.out_data !== expd[i] ||
                   if0.in_ready !== (mq.size() != DEPTH)) begin
        n_err++; $display("FAIL full_drain[%0d]: v=%b d=%h rdy=%b want 1/%h/%b", i,
                          if0.out_valid, if0.out_data, if0.in_ready, expd[i], mq.size() != DEPTH); end
      tick();
      if (i == 0) begin
        n_vec++; if (if0.in_ready !== 1'b1) begin
          n_err++; $display("FAIL full_ready_return: got %b want 1", if0.in_ready); end
      end
      if (i == 1) if0.in_valid = 1'b0;
    end
    n_vec++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin
      n_err++; $display("FAIL full_empty: v=%b rdy=%b want 0/1", if0.out_valid, if0.in_ready); end
    if0.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    if0.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if0.in_valid = 1'b1; if0.in_data = 8'($urandom); if0.control = 1'($urandom);
      tick();
    end
    base = mw0;
    if0.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if0.in_data = 8'($urandom); if0.control = 1'($urandom);
      n_vec++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b1 ||
                   if0.out_data !== mq[0][6:0] || if0.out_err !== mq[0][7]) begin
        n_err++; $display("FAIL b2b[%0d]: rdy=%b v=%b d=%h e=%b want 1/1/%h/%b", i, if0.in_ready,
                          if0.out_valid, if0.out_data, if0.out_err, mq[0][6:0], mq[0][7]); end
      tick();
    end
    if0.in_valid = 1'b0;
    n_vec++; if (wc0 !== 8'(base + 10)) begin
      n_err++; $display("FAIL b2b_word_count: got %0d want %0d", wc0, base + 10); end
    for (int i = 0; i < 2; i++) begin
      n_vec++; if (if0.out_valid !== 1'b1 || if0.out_data !== mq[0][6:0] || if0.out_err !== mq[0][7]) begin
        n_err++; $display("FAIL b2b_tail[%0d]: v=%b d=%h e=%b want 1/%h/%b", i, if0.out_valid,
                          if0.out_data, if0.out_err, mq[0][6:0], mq[0][7]); end
      tick();
    end
    n_vec++; if (if0.out_valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_empty: v=%b want 0", if0.out_valid); end
    if0.out_ready = 1'b0;
  endtask

  task automatic test_saturation();
    clear_counts = 1'b1; tick(); clear_counts = 1'b0;
    n_vec++; if (wc0 !== 8'd0 || ec0 !== 8'd0 || wc1 !== 2'd0 || ec1 !== 2'd0) begin
      n_err++; $display("FAIL sat_clear: got %0d %0d %0d %0d want all 0", wc0, ec0, wc1, ec1); end
    if0.out_ready = 1'b1; if0.in_valid = 1'b1; if0.in_data = 8'h00; if0.control = 1'b0;
    repeat (5) tick();
    if0.in_valid = 1'b0;
    n_vec++; if (wc1 !== 2'd3 || ec1 !== 2'd3 || wc0 !== 8'd5 || ec0 !== 8'd5) begin
      n_err++; $display("FAIL sat_5err: w1=%0d e1=%0d w0=%0d e0=%0d want 3/3/5/5", wc1, ec1, wc0, ec0); end
    clear_counts = 1'b1; if0.in_valid = 1'b1;
    tick();
    clear_counts = 1'b0; if0.in_valid = 1'b0;
    n_vec++; if (wc1 !== 2'd1 || ec1 !== 2'd1 || wc0 !== 8'd1 || ec0 !== 8'd1) begin
      n_err++; $display("FAIL sat_clear_inc: w1=%0d e1=%0d w0=%0d e0=%0d want all 1", wc1, ec1, wc0, ec0); end
    tick(); tick();
    n_vec++; if (if0.out_valid !== 1'b0) begin
      n_err++; $display("FAIL sat_drain: v=%b want 0", if0.out_valid); end
    if0.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      // Hold the word while it is stalled.
      if (!(if0.in_valid && mq.size() == DEPTH)) begin
        if0.in_valid = 1'($urandom);
        if0.in_data  = 8'($urandom);
        if0.control  = 1'($urandom);
      end
      if0.out_ready = ($urandom_range(0, 2) != 0) ? (i % 64 < 40) : 1'($urandom);
      clear_counts  = ($urandom_range(0, 15) == 0);
      tick();
      n_vec++; if (if0.in_ready !== (mq.size() != DEPTH) || if0.out_valid !== (mq.size() != 0)) begin
        n_err++; $display("FAIL rnd_hs[%0d]: rdy=%b v=%b want %b/%b", i, if0.in_ready,
                          if0.out_valid, mq.size() != DEPTH, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_vec++; if (if0.out_data !== mq[0][6:0] || if0.out_err !== mq[0][7]) begin
          n_err++; $display("FAIL rnd_head[%0d]: d=%h e=%b want %h/%b", i, if0.out_data,
                            if0.out_err, mq[0][6:0], mq[0][7]); end
      end
      n_vec++; if (wc0 !== 8'(mw0) || ec0 !== 8'(me0) || wc1 !== 2'(mw1) || ec1 !== 2'(me1)) begin
        n_err++; $display("FAIL rnd_cnt[%0d]: %0d %0d %0d %0d want %0d %0d %0d %0d", i,
                          wc0, ec0, wc1, ec1, mw0, me0, mw1, me1); end
    end
    clear_counts = 1'b0; if0.in_valid = 1'b0; if0.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    if0.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if0.in_valid = 1'b1; if0.in_data = 8'($urandom); if0.control = 1'($urandom);
      tick();
    end
    if0.in_valid = 1'b0;
    n_vec++; if (if0.out_valid !== 1'b1) begin
      n_err++; $display("FAIL mid_loaded: v=%b want 1", if0.out_valid); end
    rst_n = 1'b0; #1;
    n_vec++; if (if0.in_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_ready_in_reset: got %b want 0", if0.in_ready); end
    tick();
    n_vec++; if (if0.out_valid !== 1'b0 || wc0 !== 8'd0 || ec0 !== 8'd0 || wc1 !== 2'd0 || ec1 !== 2'd0) begin
      n_err++; $display("FAIL mid_reset_state: v=%b cnt %0d %0d %0d %0d want 0 all", if0.out_valid,
                        wc0, ec0, wc1, ec1); end
    rst_n = 1'b1; #1;
    n_vec++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_after_reset: rdy=%b v=%b want 1/0", if0.in_ready, if0.out_valid); end
  endtask

  initial begin
    if0.in_valid = 1'b0; if0.in_data = 8'h00; if0.control = 1'b0; if0.out_ready = 1'b0;
    test_reset();
    test_good();
    test_errored();
    test_full();
    test_back_to_back();
    test_saturation();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
